// File: rtl/elastic_buffer.sv
// elastic_buffer
//   Single-clock elastic buffer between the 8b/10b decoder and the receiver
//   status encoder. Absorbs rate mismatch between the write strobe and the
//   local read strobe. Removes a SKP from an ordered set when nearly full and
//   replays a SKP when nearly empty.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high
//   data_in        decoded symbol byte
//   data_in_k      control-symbol flag for data_in
//   data_in_valid  write strobe, one symbol per asserted cycle
//   data_out_rd    read strobe from downstream
//   data_out       registered read symbol byte
//   data_out_k     control flag for data_out
//   data_out_valid data_out/data_out_k carry a symbol this cycle
//   skip_added     one-cycle pulse, aligned with the replayed SKP
//   skip_removed   one-cycle pulse, cycle after the discarded SKP write
//   overflow       one-cycle pulse, cycle after the dropped write
//   underflow      one-cycle pulse, cycle after a read of an empty buffer
//   occupancy      stored symbol count
module elastic_buffer #(
  parameter int         DEPTH     = 16,
  parameter int         LOW_MARK  = 6,
  parameter int         HIGH_MARK = 10,
  parameter logic [7:0] COM_SYM   = 8'hBC,
  parameter logic [7:0] SKP_SYM   = 8'h1C
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 data_in,
  input  logic                       data_in_k,
  input  logic                       data_in_valid,
  input  logic                       data_out_rd,
  output logic [7:0]                 data_out,
  output logic                       data_out_k,
  output logic                       data_out_valid,
  output logic                       skip_added,
  output logic                       skip_removed,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_C   = CW'(LOW_MARK);
  localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_MARK);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_in_os, r_wr_removed;
  logic          r_rd_in_os, r_rd_added;
  logic [7:0]    r_data_out;
  logic          r_data_out_k, r_data_out_valid;
  logic          r_skip_added, r_skip_removed, r_overflow, r_underflow;

  logic [8:0] w_head;
  logic       w_in_skp, w_in_com, w_head_skp, w_head_com;
  logic       w_full, w_empty;
  logic       w_remove, w_ovf, w_store;
  logic       w_udf, w_insert, w_pop;

  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    w_in_skp   = data_in_k && (data_in == SKP_SYM);
    w_in_com   = data_in_k && (data_in == COM_SYM);
    w_head_skp = w_head[8] && (w_head[7:0] == SKP_SYM);
    w_head_com = w_head[8] && (w_head[7:0] == COM_SYM);
    w_full     = (r_count == DEPTH_C);
    w_empty    = (r_count == '0);

    // Removal outranks overflow: a droppable SKP is discarded silently
    // even when the buffer is full.
    w_remove = data_in_valid && w_in_skp && r_wr_in_os && !r_wr_removed
               && (r_count > HIGH_C);
    w_ovf    = data_in_valid && !w_remove && w_full && !data_out_rd;
    w_store  = data_in_valid && !w_remove && !w_ovf;

    // No write-to-read bypass: an empty buffer underflows even when a
    // symbol is being written in the same cycle.
    w_udf    = data_out_rd && w_empty;
    w_insert = data_out_rd && !w_empty && w_head_skp && r_rd_in_os
               && !r_rd_added && (r_count < LOW_C);
    w_pop    = data_out_rd && !w_empty && !w_insert;
  end

  // Symbol storage carries no reset; contents are only meaningful via count.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= {data_in_k, data_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_wr_in_os       <= 1'b0;
      r_wr_removed     <= 1'b0;
      r_rd_in_os       <= 1'b0;
      r_rd_added       <= 1'b0;
      r_data_out       <= '0;
      r_data_out_k     <= 1'b0;
      r_data_out_valid <= 1'b0;
      r_skip_added     <= 1'b0;
      r_skip_removed   <= 1'b0;
      r_overflow       <= 1'b0;
      r_underflow      <= 1'b0;
    end else begin
      r_skip_added     <= w_insert;
      r_skip_removed   <= w_remove;
      r_overflow       <= w_ovf;
      r_underflow      <= w_udf;
      r_data_out_valid <= w_insert || w_pop;

      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Write-side ordered-set tracking follows accepted symbols.
      if (w_remove) begin
        r_wr_removed <= 1'b1;
      end else if (w_store) begin
        if (w_in_com) begin
          r_wr_in_os   <= 1'b1;
          r_wr_removed <= 1'b0;
        end else if (!w_in_skp) begin
          r_wr_in_os   <= 1'b0;
        end
      end

      // Read-side tracking follows symbols leaving the buffer; a replayed
      // SKP arms rd_added so the same ordered set is padded only once.
      if (w_insert || w_pop) begin
        r_data_out   <= w_head[7:0];
        r_data_out_k <= w_head[8];
      end
      if (w_insert) begin
        r_rd_added <= 1'b1;
      end else if (w_pop) begin
        if (w_head_com) begin
          r_rd_in_os <= 1'b1;
          r_rd_added <= 1'b0;
        end else if (!w_head_skp) begin
          r_rd_in_os <= 1'b0;
        end
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_out_k     = r_data_out_k;
  assign data_out_valid = r_data_out_valid;
  assign skip_added     = r_skip_added;
  assign skip_removed   = r_skip_removed;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;
  assign occupancy      = r_count;

endmodule
